// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types and constants for the 8-point FFT sequencer.
// Holds the FSM states, transform size and butterfly stage offsets.
package fft8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_e;

   localparam int N     = 8;
   localparam int LOG2N = 3;

   localparam int ST1_DLY = 4;
   localparam int ST2_DLY = 6;
   localparam int ST3_DLY = 7;

   function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
      return {v[0], v[1], v[2]};
   endfunction

endpackage

// File: rtl/fft8_valid_dly.sv
// fft8_valid_dly: enable-gated tag delay line tracking which pipeline
// slots hold real samples; only advances when the datapath advances.
module fft8_valid_dly #(
   parameter int DEPTH = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] tag_q, tag_d;

   always_comb begin
      tag_d = tag_q;
      if (en) tag_d = {tag_q[DEPTH-2:0], din};
   end

   always_ff @(posedge clk) begin
      if (rst) tag_q <= '0;
      else     tag_q <= tag_d;
   end

   assign dout = tag_q[DEPTH-1];

endmodule

// File: rtl/fft8_sequencer.sv
// fft8_sequencer: stream/drain control for a pipelined 8-point FFT.
// Define FFT8_SEQ_BITREV_EN to report bins in bit-reversed order on out_idx.
module fft8_sequencer
   import fft8_pkg::*;
#(
   parameter int PIPE_LAT    = 12,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   pipe_en,
   output logic                   st1_sel,
   output logic                   st2_sel,
   output logic                   st3_sel,
   output logic [2:0]             tw_addr,
   output logic                   tw_en,
   output logic                   out_valid,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic [2:0]             out_idx,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam logic [5:0]       DRAIN_LAST = 6'(PIPE_LAT - 1);
   localparam logic [LOG2N-1:0] S_LAST     = LOG2N'(N - 1);

   seq_state_e state_q, state_d;

   logic [LOG2N-1:0]       s_q, s_d;
   logic [LOG2N-1:0]       p_q, p_d;
   logic [LOG2N-1:0]       tw_addr_q, tw_addr_d;
   logic [ST1_DLY-1:0]     sh1_q, sh1_d;
   logic [ST2_DLY-1:0]     sh2_q, sh2_d;
   logic [ST3_DLY-1:0]     sh3_q, sh3_d;
   logic [5:0]             drain_q, drain_d;
   logic                   stop_pend_q, stop_pend_d;
   logic [FRAME_CNT_W-1:0] frame_q, frame_d;

   logic accept, start_go, last_acc, tail;

   assign accept   = in_valid & in_ready;
   assign start_go = (state_q == ST_IDLE) & start;
   assign last_acc = accept & (s_q == S_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (last_acc && (stop || stop_pend_q)) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_RUN);
      busy     = (state_q != ST_IDLE);
      pipe_en  = (in_ready && in_valid) || (state_q == ST_DRAIN);
      tw_en    = pipe_en;
   end

   // s restarts on arming so every run begins frame-aligned
   always_comb begin
      s_d         = s_q;
      p_d         = p_q;
      tw_addr_d   = tw_addr_q;
      sh1_d       = sh1_q;
      sh2_d       = sh2_q;
      sh3_d       = sh3_q;
      stop_pend_d = stop_pend_q;
      frame_d     = frame_q;
      drain_d     = '0;
      if (start_go) begin
         s_d     = '0;
         frame_d = '0;
      end else if (pipe_en) begin
         s_d = s_q + LOG2N'(1);
      end
      if (pipe_en) begin
         tw_addr_d = s_q;
         sh1_d     = {sh1_q[ST1_DLY-2:0], s_q[2]};
         sh2_d     = {sh2_q[ST2_DLY-2:0], s_q[1]};
         sh3_d     = {sh3_q[ST3_DLY-2:0], s_q[0]};
      end
      if (out_valid) p_d = p_q + LOG2N'(1);
      if (out_eof) frame_d = frame_q + FRAME_CNT_W'(1);
      if (state_q == ST_RUN && stop) stop_pend_d = 1'b1;
      if (state_q != ST_RUN || state_d != ST_RUN) stop_pend_d = 1'b0;
      if (state_q == ST_DRAIN) drain_d = drain_q + 6'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q         <= '0;
         p_q         <= '0;
         tw_addr_q   <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         sh3_q       <= '0;
         drain_q     <= '0;
         stop_pend_q <= 1'b0;
         frame_q     <= '0;
      end else begin
         s_q         <= s_d;
         p_q         <= p_d;
         tw_addr_q   <= tw_addr_d;
         sh1_q       <= sh1_d;
         sh2_q       <= sh2_d;
         sh3_q       <= sh3_d;
         drain_q     <= drain_d;
         stop_pend_q <= stop_pend_d;
         frame_q     <= frame_d;
      end
   end

   fft8_valid_dly #(
      .DEPTH(PIPE_LAT)
   ) u_valid_dly (
      .clk (clk),
      .rst (rst),
      .en  (pipe_en),
      .din (accept),
      .dout(tail)
   );

   assign out_valid = pipe_en & tail;
   assign out_sof   = out_valid & (p_q == '0);
   assign out_eof   = out_valid & (p_q == S_LAST);
   assign st1_sel   = sh1_q[ST1_DLY-1];
   assign st2_sel   = sh2_q[ST2_DLY-1];
   assign st3_sel   = sh3_q[ST3_DLY-1];
   assign tw_addr   = tw_addr_q;
   assign frame_cnt = frame_q;

`ifdef FFT8_SEQ_BITREV_EN
   assign out_idx = bitrev3(p_q);
`else
   assign out_idx = p_q;
`endif

endmodule

// File: tb/tb_fft8_sequencer.sv
// tb_fft8_sequencer: directed scenarios against a log-based model of
// advances, accepted samples and produced bins, plus literal timing pins.
module tb_fft8_sequencer;

   localparam int PL = 12;

   logic clk, rst, start, stop, in_valid;
   logic in_ready, pipe_en, st1_sel, st2_sel, st3_sel, tw_en;
   logic out_valid, out_sof, out_eof, busy;
   logic [2:0] tw_addr, out_idx;
   logic [15:0] frame_cnt;

   fft8_sequencer #(.PIPE_LAT(PL), .FRAME_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .in_valid(in_valid), .in_ready(in_ready), .pipe_en(pipe_en),
      .st1_sel(st1_sel), .st2_sel(st2_sel), .st3_sel(st3_sel),
      .tw_addr(tw_addr), .tw_en(tw_en), .out_valid(out_valid),
      .out_sof(out_sof), .out_eof(out_eof), .out_idx(out_idx),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, ex);
      end
   endtask

   function automatic logic [2:0] exp_idx(input int pos);
      logic [2:0] v;
      v = 3'(pos);
`ifdef FFT8_SEQ_BITREV_EN
      return {v[0], v[1], v[2]};
`else
      return v;
`endif
   endfunction

   // model: what s was at each past advance, and whether it carried a sample
   logic [2:0] s_log[$];
   bit         acc_log[$];
   bit m_run = 0, m_drain = 0, m_pend = 0;
   int m_s = 0, outs = 0, frames = 0, drain_left = 0;

   // measurement records, re-armed whenever meas_req changes
   int meas_req = 0, meas_seen = 0, cyc = 0;
   bit got_acc = 0;
   int adv, sof_adv, t_acc, t_sof, t_eof, t_dstart, t_bfall, acc_n, ov_n;
   logic [2:0] idx_q[$];

   always @(negedge clk) begin
      bit ex_ready, ex_pipe, ex_ov, ex_st1, ex_st2, ex_st3, acc, idle;
      logic [2:0] ex_tw, lv;
      int n, pos, nxt_s;

      ex_ready = m_run;
      ex_pipe  = (m_run && in_valid) || m_drain;
      n = s_log.size();
      ex_st1 = 0; ex_st2 = 0; ex_st3 = 0; ex_tw = 0;
      if (n >= 4) begin lv = s_log[n-4]; ex_st1 = lv[2]; end
      if (n >= 6) begin lv = s_log[n-6]; ex_st2 = lv[1]; end
      if (n >= 7) begin lv = s_log[n-7]; ex_st3 = lv[0]; end
      if (n >= 1) ex_tw = s_log[n-1];
      ex_ov = ex_pipe && (n >= PL) && acc_log[n-PL];
      pos = outs % 8;

      chk("in_ready", in_ready, ex_ready);
      chk("pipe_en", pipe_en, ex_pipe);
      chk("tw_en", tw_en, ex_pipe);
      chk("busy", busy, m_run || m_drain);
      chk("st1_sel", st1_sel, ex_st1);
      chk("st2_sel", st2_sel, ex_st2);
      chk("st3_sel", st3_sel, ex_st3);
      chk("tw_addr", tw_addr, ex_tw);
      chk("out_valid", out_valid, ex_ov);
      chk("out_sof", out_sof, ex_ov && pos == 0);
      chk("out_eof", out_eof, ex_ov && pos == 7);
      chk("out_idx", out_idx, exp_idx(pos));
      chk("frame_cnt", frame_cnt, 16'(frames));

      if (meas_req != meas_seen) begin
         meas_seen = meas_req;
         got_acc = 0; adv = 0; sof_adv = -1; t_acc = -1; t_sof = -1;
         t_eof = -1; t_dstart = -1; t_bfall = -1; acc_n = 0; ov_n = 0;
         idx_q.delete();
      end
      if (got_acc && pipe_en) adv++;
      if (in_valid && in_ready) begin
         if (!got_acc) begin got_acc = 1; t_acc = cyc; end
         acc_n++;
      end
      if (got_acc && out_sof && t_sof < 0) begin t_sof = cyc; sof_adv = adv; end
      if (got_acc && out_eof && t_eof < 0) t_eof = cyc;
      if (out_valid) begin ov_n++; idx_q.push_back(out_idx); end
      if (got_acc && busy && !in_ready && t_dstart < 0) t_dstart = cyc;
      if (got_acc && !busy && t_bfall < 0) t_bfall = cyc;
      cyc++;

      if (rst) begin
         m_run = 0; m_drain = 0; m_pend = 0; m_s = 0;
         outs = 0; frames = 0; drain_left = 0;
         s_log.delete(); acc_log.delete();
      end else begin
         idle = !m_run && !m_drain;
         acc  = m_run && in_valid;
         nxt_s = ex_pipe ? (m_s + 1) % 8 : m_s;
         if (ex_pipe) begin
            s_log.push_back(3'(m_s));
            acc_log.push_back(acc);
         end
         if (ex_ov) begin
            if (pos == 7) frames++;
            outs++;
         end
         if (m_drain) begin
            drain_left--;
            if (drain_left == 0) m_drain = 0;
         end else if (m_run) begin
            if (acc && m_s == 7 && (stop || m_pend)) begin
               m_run = 0; m_drain = 1; m_pend = 0; drain_left = PL;
            end else if (stop) begin
               m_pend = 1;
            end
         end
         if (idle && start) begin
            m_run = 1; nxt_s = 0; frames = 0;
         end
         m_s = nxt_s;
      end
   end

   task automatic drive(input bit v, input bit sp, input bit st, input bit r);
      in_valid = v; stop = sp; start = st; rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_n(input int k);
      for (int i = 0; i < k; i++) drive(0, 0, 0, 0);
   endtask

   initial begin
      logic [2:0] tab[8];
      rst = 1; start = 0; stop = 0; in_valid = 0;
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      chk("reset_outs", {in_ready, pipe_en, st1_sel, st2_sel, st3_sel,
           tw_addr, tw_en, out_valid, out_sof, out_eof, out_idx, busy,
           frame_cnt}, 32'd0);

      // A: one frame back-to-back, stop pending from the first sample
      meas_req++;
      drive(0, 0, 1, 0);
      chk("ready_after_start", in_ready, 1'b1);
      for (int i = 0; i < 8; i++) drive(1, i == 0, 0, 0);
      idle_n(14);
      chk("A_sof_adv", sof_adv, 12);
      chk("A_eof_gap", t_eof - t_sof, 7);
      chk("A_drain_len", t_bfall - t_dstart, 12);
      chk("A_frame_cnt", frame_cnt, 16'd1);
      chk("A_idx_n", idx_q.size(), 8);
`ifdef FFT8_SEQ_BITREV_EN
      tab = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
      tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
      for (int i = 0; i < 8; i++)
         if (i < idx_q.size()) chk("A_idx_seq", idx_q[i], tab[i]);

      // B: three-cycle stall after sample 2
      drive(0, 0, 0, 1);
      meas_req++;
      drive(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) drive(1, i == 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0);
         chk("B_stall_hold", {pipe_en, st1_sel, st2_sel, st3_sel, tw_addr,
              out_idx}, {1'b0, 3'b000, 3'd2, 3'd0});
      end
      for (int i = 3; i < 8; i++) drive(1, 0, 0, 0);
      idle_n(14);
      chk("B_sof_cycles", t_sof - t_acc, 15);
      chk("B_frame_cnt", frame_cnt, 16'd1);

      // C: stop at sample 2 of frame 4
      meas_req++;
      drive(0, 0, 1, 0);
      for (int i = 0; i < 32; i++) drive(1, i == 26, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
      idle_n(12);
      chk("C_accepts", acc_n, 32);
      chk("C_drain_len", t_bfall - t_dstart, 12);
      chk("C_frame_cnt", frame_cnt, 16'd4);

      // D: start+stop together in RUN, start during DRAIN, then rerun
      meas_req++;
      drive(0, 0, 1, 0);
      for (int i = 0; i < 8; i++) drive(1, i == 4, i == 4, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 1, 0);
      idle_n(13);
      chk("D_idle", busy, 1'b0);
      chk("D_frame_cnt", frame_cnt, 16'd1);
      meas_req++;
      drive(0, 0, 1, 0);
      for (int i = 0; i < 8; i++) drive(1, i == 0, 0, 0);
      idle_n(14);
      chk("D2_sof_adv", sof_adv, 12);
      chk("D2_drain_len", t_bfall - t_dstart, 12);
      chk("D2_frame_cnt", frame_cnt, 16'd1);

      // E: reset mid-frame, stop in IDLE, stop on sample 7 of frame 2
      drive(0, 0, 1, 0);
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
      drive(1, 0, 0, 1);
      chk("E_reset_outs", {in_ready, pipe_en, st1_sel, st2_sel, st3_sel,
           tw_addr, tw_en, out_valid, out_sof, out_eof, out_idx, busy,
           frame_cnt}, 32'd0);
      drive(0, 1, 0, 0);
      meas_req++;
      drive(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) drive(1, i == 15, 0, 0);
      idle_n(14);
      chk("E_out_count", ov_n, 16);
      chk("E_drain_len", t_bfall - t_dstart, 12);
      chk("E_frame_cnt", frame_cnt, 16'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
